// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the integer pipeline and the HI/LO multiply-divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, operand1, operand2, input  busy, hi, lo);
  modport slave  (input  start, md_op, operand1, operand2, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: the result is computed at issue and then held back for a fixed busy latency.
// Define MULDIV_MADD_EN to enable md_op 7 (MADD, signed multiply-accumulate into {hi,lo}).
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  md
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;
  localparam logic [5:0] MUL_N    = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_N    = 6'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   pend_hi_q, pend_lo_q;
  logic               pend_we_q;

  logic               is_mul, is_div, is_madd, accept, commit, wr_hi, wr_lo;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic               a_neg, b_neg, div_signed, div_zero;
  logic [WIDTH-1:0]   ua, ub, q_u, r_u, quo, rem;

  assign a = md.operand1;
  assign b = md.operand2;

  assign is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
  assign is_div = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
`ifdef MULDIV_MADD_EN
  assign is_madd = (md.md_op == OP_MADD);
`else
  assign is_madd = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)       state_d = S_BUSY;
      S_BUSY: if (cnt_q <= 6'd1) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Output/strobe logic; MTHI/MTLO and new ops only land while idle
  always_comb begin
    accept  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    md.busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = md.start && (is_mul || is_div || is_madd);
        wr_hi  = md.start && (md.md_op == OP_MTHI);
        wr_lo  = md.start && (md.md_op == OP_MTLO);
      end
      S_BUSY: begin
        md.busy = 1'b1;
        commit  = (cnt_q <= 6'd1) && pend_we_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                 cnt_d = is_div ? DIV_N : MUL_N;
    else if (state_q == S_BUSY) cnt_d = cnt_q - 6'd1;
  end

  // Multipliers: sign/zero-extend to 2*WIDTH so the truncated product is exact
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // One unsigned divider on magnitudes; MIN/-1 falls out as MIN with remainder 0
  assign div_signed = (md.md_op == OP_DIV);
  assign div_zero   = (b == '0);
  assign a_neg      = div_signed && a[WIDTH-1];
  assign b_neg      = div_signed && b[WIDTH-1];
  assign ua         = a_neg ? -a : a;
  assign ub         = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? -b : b);
  assign q_u        = ua / ub;
  assign r_u        = ua % ub;
  assign quo        = (a_neg ^ b_neg) ? -q_u : q_u;
  assign rem        = a_neg ? -r_u : r_u;

  always_comb begin
    res = '0;
    case (md.md_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV,
      OP_DIVU:  res = {rem, quo};
`ifdef MULDIV_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
`endif
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        {pend_hi_q, pend_lo_q} <= res;
        pend_we_q              <= !(is_div && div_zero);
      end
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
      if (wr_hi) hi_q <= a;
      if (wr_lo) lo_q <= a;
    end
  end

  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width in bits.
REQ-002 Parameter MUL_CYCLES, default 5: busy cycles for multiply ops, legal range 1..63.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for divide ops, legal range 1..63.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  the op on md_op is issued this cycle.
REQ-007 md_op  input  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (see Configuration).
REQ-008 operand1  input  WIDTH  rs value, multiplicand or dividend.
REQ-009 operand2  input  WIDTH  rt value, multiplier or divisor.
REQ-010 busy  output  1  registered; an operation is in flight.
REQ-011 hi  output  WIDTH  registered HI register.
REQ-012 lo  output  WIDTH  registered LO register.

Function
REQ-013 Two-state FSM: IDLE and BUSY, plus a 6-bit down-counter.
REQ-014 In IDLE, start=1 with md_op in {1,2,3,4,7} is accepted at edge t: operands latched, result computed into pending registers, counter loaded with MUL_CYCLES (ops 1,2,7) or DIV_CYCLES (ops 3,4), state to BUSY.
REQ-015 busy=1 for exactly N cycles (t+1 .. t+N); hi/lo take the pending result on the edge that ends the last busy cycle, i.e. they are valid in the first cycle busy=0.
REQ-016 hi/lo hold their old values throughout BUSY.
REQ-017 start while BUSY is ignored (no state change, no result change); upstream stalls on busy.
REQ-018 MTHI/MTLO in IDLE: hi (resp. lo) <= operand1 on the next edge, busy stays 0; in BUSY, ignored.
REQ-019 start=1 with md_op=0, or md_op=7 with MULDIV_MADD_EN undefined: no-op.
REQ-020 MULT: signed 2*WIDTH product, {hi,lo} = product. MULTU: unsigned product.
REQ-021 DIV: signed, quotient truncated toward zero into lo, remainder (sign of dividend) into hi. DIVU: unsigned.
REQ-022 Divisor 0 (DIV or DIVU): operation still takes DIV_CYCLES busy cycles; hi and lo unchanged at completion.
REQ-023 DIV of most-negative value by -1: lo = most-negative value, hi = 0; no exception output.
REQ-024 Back-to-back: start in the first cycle busy=0 is accepted; the new op reads the already-updated hi/lo (relevant to MADD).

Reset
REQ-025 reset=1 at an edge: state IDLE, counter 0, busy=0, hi=0, lo=0, pending registers 0; overrides start in the same cycle.
REQ-026 reset during BUSY aborts the op; its result is never written.

Configuration
REQ-027 Macro MULDIV_MADD_EN defined: md_op 7 = MADD, {hi,lo} <= {hi,lo} + signed(operand1)*signed(operand2) mod 2^(2*WIDTH), MUL_CYCLES latency, accumulator sampled at acceptance.
REQ-028 Macro MULDIV_MADD_EN undefined: no accumulate logic; md_op 7 is a no-op and busy is never asserted for it.

Verification
REQ-029 MULT 0xFFFFFFFF x 0x00000002 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7 / 0 -> 10 busy cycles, hi/lo unchanged.
REQ-032 MTHI 0x12345678 then MULT 3x4 issued on cycle 2 of busy... ignored path: MTHI in idle -> hi=0x12345678 next cycle, busy=0; MTLO issued during MULT busy -> lo unaffected, MULT result written.
REQ-033 MULT 3x4 started, reset asserted on busy cycle 3 -> busy=0, hi=0, lo=0 next cycle, no later write.
REQ-034 With MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD 1x1 -> hi=0x00000001, lo=0x00000000; without the macro the same stimulus leaves hi/lo unchanged and busy=0.
